// File: rtl/mul_share_arbiter_pkg.sv
// rtl/mul_share_arbiter_pkg.sv - shared types and constants for the multiplier-sharing arbiter
package mul_share_arbiter_pkg;

    localparam int MAX_LAT    = 7;
    // Holds 0..MAX_LAT+1 outstanding operations.
    localparam int INFLIGHT_W = $clog2(MAX_LAT + 2);

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } mul_tag_t;

endpackage

// File: rtl/mul_tag_pipe.sv
// rtl/mul_tag_pipe.sv - fixed-depth shift register carrying requester tags beside the multiplier
module mul_tag_pipe
    import mul_share_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  mul_tag_t tag_i,
    output mul_tag_t tag_o
);

    mul_tag_t [DEPTH-1:0] stage_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one multiplier_array between two requesters
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int bw  = 4,
    parameter int LAT = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [bw-1:0]         req0_a,
    input  logic [bw-1:0]         req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [bw-1:0]         req1_a,
    input  logic [bw-1:0]         req1_b,
    output logic [bw-1:0]         mul_a,
    output logic [bw-1:0]         mul_b,
    input  logic [2*bw-1:0]       mul_out,
    output logic                  rsp0_valid,
    output logic [2*bw-1:0]       rsp0_data,
    output logic                  rsp1_valid,
    output logic [2*bw-1:0]       rsp1_data,
    output logic [INFLIGHT_W-1:0] inflight
);

    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic                  ret;
    mul_tag_t              tag_in;
    mul_tag_t              tag_last;

    req_id_e               rr_q, rr_d;
    logic [bw-1:0]         mul_a_q, mul_a_d;
    logic [bw-1:0]         mul_b_q, mul_b_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic [2*bw-1:0]       rsp0_data_q, rsp0_data_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [2*bw-1:0]       rsp1_data_q, rsp1_data_d;
    logic [INFLIGHT_W-1:0] inflight_q, inflight_d;

    // rr holds the last winner; the other requester wins the next tie.
    assign grant0 = req0_valid & (~req1_valid | (rr_q == REQ1));
    assign grant1 = req1_valid & (~req0_valid | (rr_q == REQ0));
    assign accept = grant0 | grant1;

    assign tag_in.valid = accept;
    assign tag_in.id    = grant1 ? REQ1 : REQ0;

    mul_tag_pipe #(
        .DEPTH (LAT + 1)
    ) u_tag_pipe (
        .clk_i (CLK),
        .rst_i (RESET),
        .tag_i (tag_in),
        .tag_o (tag_last)
    );

    assign ret = tag_last.valid;

    always_comb begin
        rr_d    = rr_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (grant0) begin
            rr_d    = REQ0;
            mul_a_d = req0_a;
            mul_b_d = req0_b;
        end else if (grant1) begin
            rr_d    = REQ1;
            mul_a_d = req1_a;
            mul_b_d = req1_b;
        end
    end

    always_comb begin
        rsp0_valid_d = ret & (tag_last.id == REQ0);
        rsp1_valid_d = ret & (tag_last.id == REQ1);
        rsp0_data_d  = rsp0_valid_d ? mul_out : rsp0_data_q;
        rsp1_data_d  = rsp1_valid_d ? mul_out : rsp1_data_q;
    end

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !ret) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!accept && ret) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rr_q         <= REQ1;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
            inflight_q   <= '0;
        end else begin
            rr_q         <= rr_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
            inflight_q   <= inflight_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_data  = rsp1_data_q;
    assign inflight   = inflight_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed self-checking bench for mul_share_arbiter at LAT=0 and LAT=3
module tb_mul_share_arbiter;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    // LAT=0 instance, combinational multiplier model
    logic       r0v, r0r, r1v, r1r;
    logic [3:0] r0a, r0b, r1a, r1b, ma, mb;
    logic [7:0] mo, d0, d1;
    logic       v0, v1;
    logic [3:0] inf;

    assign mo = ma * mb;

    mul_share_arbiter #(.bw(4), .LAT(0)) u_lat0 (
        .CLK(CLK), .RESET(RESET),
        .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b),
        .mul_a(ma), .mul_b(mb), .mul_out(mo),
        .rsp0_valid(v0), .rsp0_data(d0), .rsp1_valid(v1), .rsp1_data(d1),
        .inflight(inf)
    );

    // LAT=3 instance, multiplier modelled as three register stages
    logic       s0v, s0r, s1v, s1r;
    logic [3:0] s0a, s0b, s1a, s1b, na, nb;
    logic [7:0] no, e0, e1;
    logic       w0, w1;
    logic [3:0] inf3;
    logic [7:0] p0 = '0, p1 = '0, p2 = '0;

    always @(posedge CLK) begin
        p0 <= na * nb;
        p1 <= p0;
        p2 <= p1;
    end
    assign no = p2;

    mul_share_arbiter #(.bw(4), .LAT(3)) u_lat3 (
        .CLK(CLK), .RESET(RESET),
        .req0_valid(s0v), .req0_ready(s0r), .req0_a(s0a), .req0_b(s0b),
        .req1_valid(s1v), .req1_ready(s1r), .req1_a(s1a), .req1_b(s1b),
        .mul_a(na), .mul_b(nb), .mul_out(no),
        .rsp0_valid(w0), .rsp0_data(e0), .rsp1_valid(w1), .rsp1_data(e1),
        .inflight(inf3)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        {r0v, r1v, s0v, s1v} = '0;
        {r0a, r0b, r1a, r1b} = '0;
        {s0a, s0b, s1a, s1b} = '0;
        #1;
        chk("reset_mul_a", ma, 0);
        chk("reset_inflight", inf, 0);
        chk("reset_rsp", {v0, v1, d0, d1}, 0);
        tick();
        tick();
        RESET = 1'b0;

        // single requester 3x5
        r0v = 1; r0a = 3; r0b = 5;
        #1;
        chk("single_ready0", r0r, 1);
        chk("single_ready1", r1r, 0);
        tick();
        r0v = 0;
        chk("single_mul_a", ma, 3);
        chk("single_mul_b", mb, 5);
        chk("single_inflight", inf, 1);
        chk("single_rsp0_early", v0, 0);
        tick();
        chk("single_rsp0_valid", v0, 1);
        chk("single_rsp0_data", d0, 15);
        chk("single_rsp1_valid", v1, 0);
        chk("single_inflight_ret", inf, 0);
        tick();
        chk("single_pulse_end", v0, 0);
        chk("single_data_hold", d0, 15);
        chk("idle_mul_a_hold", ma, 3);

        // req1 alone with boundary 0x15, then two idle cycles
        r1v = 1; r1a = 0; r1b = 15;
        #1;
        chk("alone_ready1", r1r, 1);
        chk("alone_ready0", r0r, 0);
        tick();
        r1v = 0;
        tick();
        chk("zero_rsp1_valid", v1, 1);
        chk("zero_rsp1_data", d1, 0);
        chk("zero_rsp0_hold", d0, 15);
        tick();

        // both valid for four cycles: 0 wins the tie, then strict alternation
        r0v = 1; r0a = 15; r0b = 15;
        r1v = 1; r1a = 2;  r1b = 7;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_ready0", r0r, (i % 2 == 0));
            chk("alt_ready1", r1r, (i % 2 == 1));
            tick();
            chk("alt_mul_a", ma, (i % 2 == 0) ? 15 : 2);
            chk("alt_inflight", inf, 1);
            if (i > 0) begin
                if ((i - 1) % 2 == 0) begin
                    chk("alt_rsp0_valid", v0, 1);
                    chk("alt_rsp0_data", d0, 8'hE1);
                    chk("alt_rsp1_idle", v1, 0);
                end else begin
                    chk("alt_rsp1_valid", v1, 1);
                    chk("alt_rsp1_data", d1, 14);
                    chk("alt_rsp0_idle", v0, 0);
                end
            end
        end
        r0v = 0; r1v = 0;
        tick();
        chk("alt_last_rsp1", v1, 1);
        chk("alt_last_data", d1, 14);
        chk("alt_last_rsp0", v0, 0);
        chk("alt_drain", inf, 0);

        // reset with one operation in flight
        r0v = 1; r0a = 3; r0b = 3;
        tick();
        r0v = 0;
        chk("pre_reset_inflight", inf, 1);
        RESET = 1'b1;
        #1;
        chk("async_mul_a", ma, 0);
        chk("async_mul_b", mb, 0);
        chk("async_inflight", inf, 0);
        chk("async_rsp", {v0, v1, d0, d1}, 0);
        tick();
        RESET = 1'b0;
        tick();
        chk("post_reset_no_rsp", {v0, v1}, 0);
        chk("post_reset_inflight", inf, 0);
        r0v = 1; r1v = 1;
        #1;
        chk("post_reset_tie0", r0r, 1);
        chk("post_reset_tie1", r1r, 0);
        r0v = 0; r1v = 0;
        tick();

        // LAT=3 streaming 1x1 .. 6x6 from requester 1
        for (int t = 1; t <= 12; t++) begin
            int acc, rtn, k;
            if (t <= 6) begin
                s1v = 1; s1a = 4'(t); s1b = 4'(t);
                #1;
                chk("lat3_ready1", s1r, 1);
            end else begin
                s1v = 0;
            end
            tick();
            acc = (t <= 6) ? t : 6;
            rtn = (t >= 5) ? ((t - 4 < 6) ? t - 4 : 6) : 0;
            k   = t - 4;
            chk("lat3_inflight", inf3, 16'(acc - rtn));
            chk("lat3_rsp0", w0, 0);
            if (k >= 1 && k <= 6) begin
                chk("lat3_rsp1_valid", w1, 1);
                chk("lat3_rsp1_data", e1, 16'(k * k));
            end else begin
                chk("lat3_rsp1_idle", w1, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
